bemicro_cva9_key_reader: RTL
============================

Name: bemicro_cva9_key_reader

Overview:
- Input-side companion to the board's LED output logic: reads the active-low user push buttons, debounces them, and reports clean levels, one-cycle press/release pulses and an 8-bit press counter.
- The 8-bit press counter is sized to drive the 8 user LEDs.
- Sits directly behind the board's push-button pins, in the 24 MHz clock domain.

Parameters:
- NUM_KEYS, 2, number of push-button inputs (1..8).
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a level change (10 ms at 24 MHz); minimum 2.
- CNT_WIDTH, 18, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- CLK_24MHZ  input  1  board clock; sole clock of the block.
- RESET  input  1  synchronous, active-high reset.
- KEY_N  input  NUM_KEYS  raw push buttons, active low, asynchronous to the clock.
- KEY_STATE  output  NUM_KEYS  debounced level, 1 = pressed.
- KEY_PRESS  output  NUM_KEYS  one-cycle pulse on accepted press.
- KEY_RELEASE  output  NUM_KEYS  one-cycle pulse on accepted release.
- PRESS_COUNT  output  8  number of accepted presses of key 0, modulo 256.

Behaviour:
- One clock, CLK_24MHZ. Reset is synchronous and active-high on RESET, sampled on the rising edge. All state is updated on the rising edge.
- Reset values:
  - Two-flop synchronizer per key: 1 (released).
  - FSM: RELEASED.
  - Debounce counters: 0.
  - KEY_STATE, KEY_PRESS, KEY_RELEASE, PRESS_COUNT: 0.
  - A key held down through reset produces no pulse on the reset cycle. Its press is accepted normally after reset, through the full debounce path.
- Synchronizer: KEY_N[i] passes through 2 flops to give s[i]. No logic reads the first flop.
- Per-key FSM, with keys fully independent. States and transitions:
  - RELEASED: if s=0, go to PRESS_CHK and set cnt to 0.
  - PRESS_CHK:
    - If s=1, return to RELEASED and set cnt to 0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and set cnt to 0.
    - Else increment cnt.
  - PRESSED: if s=1, go to RELEASE_CHK and set cnt to 0.
  - RELEASE_CHK:
    - If s=0, return to PRESSED and set cnt to 0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED and set cnt to 0.
    - Else increment cnt.
- Outputs are registered:
  - KEY_STATE[i] = 1 in PRESSED or RELEASE_CHK.
  - KEY_PRESS[i] is high for exactly the one cycle after the PRESS_CHK->PRESSED transition edge.
  - KEY_RELEASE[i] is high for exactly the one cycle after the RELEASE_CHK->RELEASED transition edge.
- Latency: edge 0 is the first edge sampling KEY_N[i]=0, and the input stays low. KEY_STATE[i] and KEY_PRESS[i] are high after edge DEBOUNCE_CYCLES+2. Release latency is the same.
- PRESS_COUNT:
  - Increments by 1 on the same edge that raises KEY_PRESS[0].
  - Wraps from 255 to 0 with no flag.
  - Other keys do not affect it.
- Simultaneous events:
  - Keys pressing or releasing on the same cycle each produce their own pulse.
  - KEY_PRESS and KEY_RELEASE for one key are never high together.
  - The minimum spacing between a press pulse and a release pulse on one key is DEBOUNCE_CYCLES+1 cycles.
- Reset mid-debounce: FSM, cnt and outputs return to their reset values on the reset edge. No pulse is emitted on that edge.
- Counter arithmetic: cnt is CNT_WIDTH bits, unsigned, and never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and NUM_KEYS=2 for scenarios 1–5.
- 1. Clean press: KEY_N=2'b11 after reset; drive KEY_N[0]=0 and hold -> KEY_STATE[0]=1 and KEY_PRESS[0]=1 after edge 6, KEY_PRESS[0] lasts 1 cycle, PRESS_COUNT=1; later KEY_N[0]=1 and hold -> KEY_RELEASE[0] pulses once after edge 6, KEY_STATE[0]=0.
- 2. Bounce rejection: KEY_N[0] goes low for 3 cycles, high for 1 cycle, low for 3 cycles, then high -> no KEY_PRESS, KEY_STATE stays 0, PRESS_COUNT stays 0.
- 3. Simultaneous keys: both keys go low on the same edge -> KEY_PRESS=2'b11 on the same cycle; PRESS_COUNT increments by 1 only.
- 4. Wrap: 256 debounced presses of key 0 -> PRESS_COUNT reads 255 then 0; exactly 256 KEY_PRESS[0] pulses are counted.
- 5. Reset mid-operation:
  - Assert RESET for 1 cycle during PRESS_CHK -> all outputs 0, no pulse.
  - Assert RESET while the key is held low -> after release of RESET, the press is accepted after edge 6 (counted from the first post-reset edge), with 1 pulse.
- 6. Default parameters: hold key 1 low -> KEY_PRESS[1] after edge 240002, none before.

Source files
------------

// File: rtl/bemicro_cva9_key_reader.sv
// Push-button front end: two-flop synchronizer, per-key debounce FSM,
// registered level / press / release outputs and a key-0 press counter.
module bemicro_cva9_key_reader #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic                CLK_24MHZ,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY_N,
    output logic [NUM_KEYS-1:0] KEY_STATE,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [7:0]          PRESS_COUNT
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_fsm_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]  sync_meta;
    logic [NUM_KEYS-1:0]  sync_key_n;
    key_fsm_t             state_q [NUM_KEYS];
    key_fsm_t             state_d [NUM_KEYS];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_KEYS];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0]  key_state_d;
    logic [NUM_KEYS-1:0]  key_press_d;
    logic [NUM_KEYS-1:0]  key_release_d;
    logic [7:0]           press_count_d;

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i]       = state_q[i];
            cnt_d[i]         = cnt_q[i];
            key_press_d[i]   = 1'b0;
            key_release_d[i] = 1'b0;
            unique case (state_q[i])
                RELEASED: begin
                    if (!sync_key_n[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (sync_key_n[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = PRESSED;
                        cnt_d[i]       = '0;
                        key_press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync_key_n[i]) begin
                        state_d[i] = RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!sync_key_n[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]       = RELEASED;
                        cnt_d[i]         = '0;
                        key_release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level output tracks the state being entered so it rises with the press pulse.
            key_state_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
        end
        press_count_d = PRESS_COUNT + 8'(key_press_d[0]);
    end

    always_ff @(posedge CLK_24MHZ) begin
        if (RESET) begin
            sync_meta   <= '1;
            sync_key_n  <= '1;
            KEY_STATE   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            PRESS_COUNT <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_meta   <= KEY_N;
            sync_key_n  <= sync_meta;
            KEY_STATE   <= key_state_d;
            KEY_PRESS   <= key_press_d;
            KEY_RELEASE <= key_release_d;
            PRESS_COUNT <= press_count_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule
